pattern_ddr3_load: RTL and testbench
====================================

Name: pattern_ddr3_load

Overview:
Write-side counterpart of the pattern fetch path. Takes a 32-bit pattern stream from the host/loader and packs it into 256-bit words: one header word first, then pattern body words. Writes these words sequentially into DDR3 over the EMIF (Avalon-MM style) interface. It first clears the on-chip "loaded" flag, and sets it to FLAG_VALUE once the final word has been accepted, so the fetch path only starts reading complete data.

Parameters:
DDR_BASE_ADDR, 22'h0, DDR3 word address of the header; body words follow at consecutive addresses.
FLAG_VALUE, 256'h55, value written to on-chip address 0 when the load completes.
FLAG_ADDR, 11'h0, on-chip memory address of the loaded flag.

Ports:
ddr_emif_clk  in  1  sole clock
ddr_emif_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load (ignored unless IDLE)
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&&s_ready
s_data  in  32  stream word; first word of each beat lands in [255:224]
ddr_emif_ready  in  1  EMIF can accept a command this cycle
ddr_emif_write  out  1  write request
ddr_emif_read  out  1  tied 0
ddr_emif_addr  out  22  word address
ddr_emif_write_data  out  256  write data
ddr_emif_byte_enable  out  32  all ones while writing, else 0
ddr_emif_burst_count  out  5  constant 5'd1
onchip_mem_clken, onchip_mem_chip_select, onchip_mem_write  out  1 each  on-chip write strobes
onchip_mem_addr  out  11  on-chip address
onchip_mem_write_data  out  256  on-chip data
onchip_mem_byte_enable  out  32  all ones during on-chip write
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the flag write issues
err  out  1  sticky size error; cleared by the next start

Behaviour:
- Reset: every output is 0, except ddr_emif_burst_count = 1. The FSM goes to IDLE; the beat assembly register and counters are cleared. Reset mid-load abandons the load. The flag keeps whatever value it last had (0 if CLR_FLAG already ran).
- FSM states: IDLE, CLR_FLAG, COLLECT, WR, FLAG.
- IDLE: on start, clear err, set addr = DDR_BASE_ADDR, set hdr_phase = 1, go to CLR_FLAG.
- CLR_FLAG: issue one on-chip write (clken, cs, write, byte_enable all high; addr = FLAG_ADDR; data = 0), then go to COLLECT.
- COLLECT:
  - s_ready = 1.
  - Each accepted word shifts into the 256-bit assembly register MSB-first, and word_cnt (3-bit) increments.
  - When the 8th word is accepted, the register loads ddr_emif_write_data and the FSM goes to WR on the next cycle.
  - s_ready is 0 in every state other than COLLECT.
- WR:
  - ddr_emif_write = 1; addr and data are held stable until a cycle with ddr_emif_ready = 1. That edge completes the write.
  - Then addr increments by 1, wrapping modulo 2^22.
  - Header beat (hdr_phase = 1):
    - Latch total_pix = [191:160] and pat_num = [159:128].
    - beats_per_pat = total_pix[31:8] + |total_pix[7:0].
    - body_left = pat_num * beats_per_pat, computed at 64-bit width.
    - If body_left == 0 or body_left > 2^22-1-addr_after_header: set err, go to IDLE without setting the flag.
    - Otherwise clear hdr_phase and go to COLLECT.
  - Body beat: decrement body_left; at 0 go to FLAG, else go to COLLECT.
  - ddr_emif_write deasserts in the cycle after acceptance. Back-to-back beats therefore have at least 9 cycles between write acceptances.
- FLAG: one on-chip write of FLAG_VALUE to FLAG_ADDR, with done pulsed in the same cycle; then go to IDLE.
- start outside IDLE is ignored. s_valid while s_ready = 0 is held off; no words are lost.
- On-chip strobes are single-cycle; the on-chip memory has no wait state.

Optional Feature:
PAT_LOAD_CHECKSUM_EN
- Defined: a 32-bit sum (modulo 2^32) of all accepted body stream words, excluding header words, is accumulated. In FLAG, a second on-chip write of {224'h0, sum} to FLAG_ADDR+1 issues one cycle before the flag write, so FLAG takes 2 cycles. The sum clears on start.
- Undefined: no accumulator; FLAG is a single cycle.

Decomposition:
Shared package pattern_pkg:
- FSM state encoding.
- Header field bit positions: H_PIX [255:224], V_PIX [223:192], TOTAL_PIX [191:160], PAT_NUM [159:128], FILL_SIZE [127:96], START_ADDR [95:64], END_ADDR [63:32], RSV [31:0].
- PIX_PER_BEAT = 256 and FLAG_VALUE.
- A function beats_per_pattern(total_pix), so that load and fetch use identical rounding.

One natural sub-module, pattern_beat_packer: the 32-to-256 shift register, word counter and beat-ready flag.

Test Plan:
- Header total_pix = 512, pat_num = 2, followed by 32 body words with ready always 1 -> exactly 5 DDR writes at addr 0..4, data matches packed words MSB-first; on-chip writes are 0 then 0x55; done pulses once; err = 0.
- total_pix = 300 (rounds up to 2 beats), pat_num = 1 -> 3 DDR writes; 0x55 is written only after the addr 2 write is accepted.
- ddr_emif_ready held low for 7 cycles during the body write at addr 1 -> write, addr and data are stable all 7 cycles; s_ready stays 0; no stream word is lost.
- Header pat_num = 0 -> err = 1 after the header write; no 0x55 write; busy drops; the next start clears err.
- Async reset asserted mid-body with 3 of 8 words collected -> all outputs at reset values immediately; a following start performs a clean load from addr 0.
- With PAT_LOAD_CHECKSUM_EN: body words 1..16 (total_pix = 512, pat_num = 1) -> on-chip addr 1 = 32'd136 written before the addr 0 flag write.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern load/fetch paths: FSM encoding, header layout,
// beat geometry and the beats-per-pattern rounding both paths must agree on.
package pattern_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_FLAG,
        S_COLLECT,
        S_WR,
        S_FLAG
    } state_e;

    // Header word layout, MSB first: the first stream word lands in h_pix.
    typedef struct packed {
        logic [31:0] h_pix;
        logic [31:0] v_pix;
        logic [31:0] total_pix;
        logic [31:0] pat_num;
        logic [31:0] fill_size;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
        logic [31:0] rsv;
    } pat_header_t;

    localparam int           PIX_PER_BEAT   = 256;
    localparam int           PIX_SHIFT      = $clog2(PIX_PER_BEAT);
    localparam logic [255:0] DEF_FLAG_VALUE = 256'h55;

    // Round total_pix up to whole beats; 25 bits because all-ones rounds to 2^24.
    function automatic logic [24:0] beats_per_pattern(input logic [31:0] total_pix);
        return {1'b0, total_pix[31:PIX_SHIFT]} + {24'h0, |total_pix[PIX_SHIFT-1:0]};
    endfunction

endpackage

// File: rtl/pattern_beat_packer.sv
// Packs 32-bit stream words MSB-first into a 256-bit beat; flags the eighth word.
module pattern_beat_packer
    import pattern_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         word_vld_i,
    input  logic [31:0]  word_i,
    output logic [255:0] beat_o,
    output logic         beat_full_o
);

    logic [255:0] shift_q;
    logic [255:0] shift_d;
    logic [2:0]   cnt_q;

    // beat_o already includes the word being accepted so the full beat is usable on the 8th edge.
    assign shift_d     = {shift_q[223:0], word_i};
    assign beat_o      = shift_d;
    assign beat_full_o = word_vld_i && (cnt_q == 3'd7);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (word_vld_i) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/pattern_ddr3_load.sv
// Loads a 32-bit pattern stream into DDR3 as 256-bit beats (header then body) and
// brackets the load with the on-chip loaded flag. Option: PAT_LOAD_CHECKSUM_EN.
module pattern_ddr3_load
    import pattern_pkg::*;
#(
    parameter logic [21:0]  DDR_BASE_ADDR = 22'h0,
    parameter logic [255:0] FLAG_VALUE    = DEF_FLAG_VALUE,
    parameter logic [10:0]  FLAG_ADDR     = 11'h0
) (
    input  logic         ddr_emif_clk,
    input  logic         ddr_emif_rst_n,
    input  logic         start,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         ddr_emif_ready,
    output logic         ddr_emif_write,
    output logic         ddr_emif_read,
    output logic [21:0]  ddr_emif_addr,
    output logic [255:0] ddr_emif_write_data,
    output logic [31:0]  ddr_emif_byte_enable,
    output logic [4:0]   ddr_emif_burst_count,
    output logic         onchip_mem_clken,
    output logic         onchip_mem_chip_select,
    output logic         onchip_mem_write,
    output logic [10:0]  onchip_mem_addr,
    output logic [255:0] onchip_mem_write_data,
    output logic [31:0]  onchip_mem_byte_enable,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e       state_q;
    logic [21:0]  addr_q;
    logic [255:0] wdata_q;
    logic [63:0]  body_left_q;
    logic         hdr_phase_q;
    logic         err_q;
    logic         write_q;
    logic         s_ready_q;
    logic         oc_wr_q;
    logic         done_q;
    logic [10:0]  oc_addr_q;
    logic [255:0] oc_data_q;
`ifdef PAT_LOAD_CHECKSUM_EN
    logic [31:0]  sum_q;
    logic         cksum_done_q;
`endif

    logic         accept;
    logic [255:0] beat;
    logic         beat_full;

    assign accept = s_valid && s_ready_q;

    pattern_beat_packer u_packer (
        .clk_i       (ddr_emif_clk),
        .rst_ni      (ddr_emif_rst_n),
        .word_vld_i  (accept),
        .word_i      (s_data),
        .beat_o      (beat),
        .beat_full_o (beat_full)
    );

    pat_header_t  hdr;
    logic [24:0]  hdr_bpp;
    logic [63:0]  hdr_body;
    logic [63:0]  hdr_room;
    logic [21:0]  addr_inc;
    logic         hdr_bad;

    // Room left above the header is 2^22-1-addr_inc, i.e. the bitwise complement.
    assign hdr      = pat_header_t'(wdata_q);
    assign hdr_bpp  = beats_per_pattern(hdr.total_pix);
    assign hdr_body = {32'h0, hdr.pat_num} * {39'h0, hdr_bpp};
    assign addr_inc = addr_q + 22'd1;
    assign hdr_room = {42'h0, ~addr_inc};
    assign hdr_bad  = (hdr_body == 64'd0) || (hdr_body > hdr_room);

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            body_left_q  <= '0;
            hdr_phase_q  <= 1'b0;
            err_q        <= 1'b0;
            write_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            oc_wr_q      <= 1'b0;
            done_q       <= 1'b0;
            oc_addr_q    <= '0;
            oc_data_q    <= '0;
`ifdef PAT_LOAD_CHECKSUM_EN
            sum_q        <= '0;
            cksum_done_q <= 1'b0;
`endif
        end else begin
            oc_wr_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q       <= 1'b0;
                        addr_q      <= DDR_BASE_ADDR;
                        hdr_phase_q <= 1'b1;
                        oc_wr_q     <= 1'b1;
                        oc_addr_q   <= FLAG_ADDR;
                        oc_data_q   <= '0;
`ifdef PAT_LOAD_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                        state_q     <= S_CLR_FLAG;
                    end
                end
                S_CLR_FLAG: begin
                    s_ready_q <= 1'b1;
                    state_q   <= S_COLLECT;
                end
                S_COLLECT: begin
`ifdef PAT_LOAD_CHECKSUM_EN
                    if (accept && !hdr_phase_q) begin
                        sum_q <= sum_q + s_data;
                    end
`endif
                    if (beat_full) begin
                        wdata_q   <= beat;
                        s_ready_q <= 1'b0;
                        write_q   <= 1'b1;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (ddr_emif_ready) begin
                        write_q <= 1'b0;
                        addr_q  <= addr_inc;
                        if (hdr_phase_q) begin
                            if (hdr_bad) begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                hdr_phase_q <= 1'b0;
                                body_left_q <= hdr_body;
                                s_ready_q   <= 1'b1;
                                state_q     <= S_COLLECT;
                            end
                        end else begin
                            body_left_q <= body_left_q - 64'd1;
                            if (body_left_q == 64'd1) begin
                                oc_wr_q   <= 1'b1;
`ifdef PAT_LOAD_CHECKSUM_EN
                                oc_addr_q <= FLAG_ADDR + 11'd1;
                                oc_data_q <= {224'h0, sum_q};
`else
                                oc_addr_q <= FLAG_ADDR;
                                oc_data_q <= FLAG_VALUE;
                                done_q    <= 1'b1;
`endif
                                state_q   <= S_FLAG;
                            end else begin
                                s_ready_q <= 1'b1;
                                state_q   <= S_COLLECT;
                            end
                        end
                    end
                end
                S_FLAG: begin
`ifdef PAT_LOAD_CHECKSUM_EN
                    // Checksum write occupies the first FLAG cycle, the flag itself the second.
                    if (!cksum_done_q) begin
                        oc_wr_q      <= 1'b1;
                        oc_addr_q    <= FLAG_ADDR;
                        oc_data_q    <= FLAG_VALUE;
                        done_q       <= 1'b1;
                        cksum_done_q <= 1'b1;
                    end else begin
                        cksum_done_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready                = s_ready_q;
    assign ddr_emif_write         = write_q;
    assign ddr_emif_read          = 1'b0;
    assign ddr_emif_addr          = addr_q;
    assign ddr_emif_write_data    = wdata_q;
    assign ddr_emif_byte_enable   = {32{write_q}};
    assign ddr_emif_burst_count   = 5'd1;
    assign onchip_mem_clken       = oc_wr_q;
    assign onchip_mem_chip_select = oc_wr_q;
    assign onchip_mem_write       = oc_wr_q;
    assign onchip_mem_addr        = oc_addr_q;
    assign onchip_mem_write_data  = oc_data_q;
    assign onchip_mem_byte_enable = {32{oc_wr_q}};
    assign busy                   = (state_q != S_IDLE);
    assign done                   = done_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_pattern_ddr3_load.sv
// Bench for pattern_ddr3_load: vector table, randomized loads, stall/reset/checksum sequences.
module tb_pattern_ddr3_load;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         s_valid = 1'b0;
    logic [31:0]  s_data = '0;
    logic         ready = 1'b0;
    logic         s_ready, ddr_emif_write, ddr_emif_read;
    logic [21:0]  ddr_emif_addr;
    logic [255:0] ddr_emif_write_data, onchip_mem_write_data;
    logic [31:0]  ddr_emif_byte_enable, onchip_mem_byte_enable;
    logic [4:0]   ddr_emif_burst_count;
    logic         onchip_mem_clken, onchip_mem_chip_select, onchip_mem_write;
    logic [10:0]  onchip_mem_addr;
    logic         busy, done, err;

    pattern_ddr3_load dut (
        .ddr_emif_clk           (clk),
        .ddr_emif_rst_n         (rst_n),
        .start                  (start),
        .s_valid                (s_valid),
        .s_ready                (s_ready),
        .s_data                 (s_data),
        .ddr_emif_ready         (ready),
        .ddr_emif_write         (ddr_emif_write),
        .ddr_emif_read          (ddr_emif_read),
        .ddr_emif_addr          (ddr_emif_addr),
        .ddr_emif_write_data    (ddr_emif_write_data),
        .ddr_emif_byte_enable   (ddr_emif_byte_enable),
        .ddr_emif_burst_count   (ddr_emif_burst_count),
        .onchip_mem_clken       (onchip_mem_clken),
        .onchip_mem_chip_select (onchip_mem_chip_select),
        .onchip_mem_write       (onchip_mem_write),
        .onchip_mem_addr        (onchip_mem_addr),
        .onchip_mem_write_data  (onchip_mem_write_data),
        .onchip_mem_byte_enable (onchip_mem_byte_enable),
        .busy                   (busy),
        .done                   (done),
        .err                    (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [21:0] addr; logic [255:0] data; } ddr_t;
    typedef struct { logic [10:0] addr; logic [255:0] data; int seen; } oc_t;
    typedef struct { logic [31:0] tp; logic [31:0] pn; int wr; bit e; } vec_t;

    ddr_t         ddr_q[$];
    oc_t          oc_q[$];
    logic [31:0]  words_q[$];
    logic [255:0] expd_g[$];
    logic [31:0]  sum_g;
    int           exp_wr_g;
    bit           exp_err_g;
    int           pass_cnt = 0, total_cnt = 0;
    int           done_cnt, acc_cnt, cyc = 0, last_acc, min_gap;
    bit           rand_valid = 0, rand_ready = 0, stall_en = 0;
    int           stall_left = 0, stall_seen = 0;
    logic [255:0] stall_exp;
    vec_t         tbl[10];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Stream and EMIF ready driven just after the active edge.
    always @(posedge clk) begin
        #1;
        if (words_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            s_valid = 1'b1;
            s_data  = words_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
        end
        if (stall_en && stall_left > 0 && ddr_emif_write && ddr_emif_addr == 22'd1) begin
            ready = 1'b0;
            stall_left--;
        end else begin
            ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Observation on the falling edge: what is seen here is taken by the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (s_valid && s_ready) begin
                void'(words_q.pop_front());
                acc_cnt++;
            end
            if (ddr_emif_write && ready) begin
                ddr_q.push_back('{ddr_emif_addr, ddr_emif_write_data});
                check("ddr_be", ddr_emif_byte_enable, 256'hFFFF_FFFF);
                if (last_acc >= 0 && cyc - last_acc < min_gap) min_gap = cyc - last_acc;
                last_acc = cyc;
            end
            if (onchip_mem_write) begin
                oc_q.push_back('{onchip_mem_addr, onchip_mem_write_data, ddr_q.size()});
                check("oc_strobes", {onchip_mem_clken, onchip_mem_chip_select, onchip_mem_byte_enable}, {2'b11, 32'hFFFF_FFFF});
            end
            if (done) done_cnt++;
            if (stall_en && ddr_emif_write && !ready && ddr_emif_addr == 22'd1) begin
                stall_seen++;
                check("stall_data", ddr_emif_write_data, stall_exp);
                check("stall_sready", s_ready, 1'b0);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {ddr_emif_write, ddr_emif_read, onchip_mem_clken, onchip_mem_chip_select,
                              onchip_mem_write, busy, done, err, s_ready}, 9'h0);
        check({tag, "_addr"}, {ddr_emif_addr, onchip_mem_addr}, 33'h0);
        check({tag, "_wdata"}, ddr_emif_write_data, 256'h0);
        check({tag, "_ocdata"}, onchip_mem_write_data, 256'h0);
        check({tag, "_be"}, {ddr_emif_byte_enable, onchip_mem_byte_enable}, 64'h0);
        check({tag, "_burst"}, ddr_emif_burst_count, 5'd1);
    endtask

    // Reference: header word layout, beats rounded up per pattern, words packed MSB-first.
    task automatic start_load(input logic [31:0] tp, input logic [31:0] pn, input int exp_wr,
                              input bit exp_err, input bit seq_words);
        logic [31:0]  w[$];
        logic [255:0] d;
        w = {};
        w.push_back($urandom); w.push_back($urandom); w.push_back(tp); w.push_back(pn);
        w.push_back($urandom); w.push_back($urandom); w.push_back($urandom); w.push_back($urandom);
        sum_g = '0;
        if (!exp_err) begin
            for (int i = 0; i < (exp_wr - 1) * 8; i++) begin
                d[31:0] = seq_words ? 32'(i + 1) : $urandom;
                w.push_back(d[31:0]);
                sum_g = sum_g + d[31:0];
            end
        end
        expd_g = {};
        for (int b = 0; b < exp_wr; b++) begin
            d = '0;
            for (int i = 0; i < 8; i++) d[255 - 32 * i -: 32] = w[8 * b + i];
            expd_g.push_back(d);
        end
        stall_exp = (exp_wr > 1) ? expd_g[1] : '0;
        exp_wr_g  = exp_wr;
        exp_err_g = exp_err;
        ddr_q = {}; oc_q = {};
        done_cnt = 0; acc_cnt = 0; last_acc = -1; min_gap = 100000; stall_seen = 0;
        words_q = w;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int n;
        int n_oc;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_busy_drop"}, busy, 1'b0);
        check({tag, "_nwr"}, ddr_q.size(), exp_wr_g);
        for (int i = 0; i < ddr_q.size() && i < exp_wr_g; i++) begin
            check($sformatf("%s_addr%0d", tag, i), ddr_q[i].addr, 22'(i));
            check($sformatf("%s_data%0d", tag, i), ddr_q[i].data, expd_g[i]);
        end
        check({tag, "_err"}, err, exp_err_g);
        check({tag, "_done"}, done_cnt, exp_err_g ? 0 : 1);
        check({tag, "_words_left"}, words_q.size(), 0);
`ifdef PAT_LOAD_CHECKSUM_EN
        n_oc = exp_err_g ? 1 : 3;
`else
        n_oc = exp_err_g ? 1 : 2;
`endif
        check({tag, "_noc"}, oc_q.size(), n_oc);
        if (oc_q.size() > 0) check({tag, "_clr"}, {oc_q[0].addr, oc_q[0].data}, {11'h0, 256'h0});
        if (!exp_err_g && oc_q.size() == n_oc) begin
            check({tag, "_flag"}, {oc_q[n_oc - 1].addr, oc_q[n_oc - 1].data}, {11'h0, 256'h55});
            check({tag, "_flag_after_last"}, oc_q[n_oc - 1].seen, exp_wr_g);
`ifdef PAT_LOAD_CHECKSUM_EN
            check({tag, "_cksum"}, {oc_q[1].addr, oc_q[1].data}, {11'h1, 224'h0, sum_g});
`endif
        end
        if (!rand_ready && !stall_en && exp_wr_g > 1) check({tag, "_gap9"}, min_gap >= 9, 1'b1);
    endtask

    task automatic run_load(input logic [31:0] tp, input logic [31:0] pn, input int exp_wr,
                            input bit exp_err, input bit seq_words, input string tag);
        start_load(tp, pn, exp_wr, exp_err, seq_words);
        @(negedge clk);
        check({tag, "_start"}, {busy, err}, 2'b10);
        finish_load(tag);
    endtask

    initial begin
        int n;
        logic [31:0] tp, pn;
        tbl[0] = '{32'd512, 32'd2, 5, 1'b0};
        tbl[1] = '{32'd300, 32'd1, 3, 1'b0};
        tbl[2] = '{32'd256, 32'd1, 2, 1'b0};
        tbl[3] = '{32'd1,   32'd3, 4, 1'b0};
        tbl[4] = '{32'd512, 32'd0, 1, 1'b1};
        tbl[5] = '{32'd257, 32'd2, 5, 1'b0};
        tbl[6] = '{32'd0,   32'd5, 1, 1'b1};
        tbl[7] = '{32'hFFFF_FF01, 32'd1, 1, 1'b1};
        tbl[8] = '{32'd256, 32'hFFFF_FFFF, 1, 1'b1};
        tbl[9] = '{32'd768, 32'd1, 4, 1'b0};

        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            rand_valid = (i % 2) == 1;
            rand_ready = (i % 2) == 1;
            run_load(tbl[i].tp, tbl[i].pn, tbl[i].wr, tbl[i].e, 1'b0, $sformatf("vec%0d", i));
        end

        rand_valid = 1; rand_ready = 1;
        for (int k = 0; k < 6; k++) begin
            tp = $urandom_range(1, 1100);
            pn = $urandom_range(1, 3);
            run_load(tp, pn, 1 + int'(pn) * ((int'(tp) + 255) / 256), 1'b0, 1'b0, $sformatf("rnd%0d", k));
        end

        rand_valid = 0; rand_ready = 0;
        stall_en = 1; stall_left = 7;
        run_load(32'd512, 32'd1, 3, 1'b0, 1'b0, "stall");
        check("stall_cycles", stall_seen, 7);
        stall_en = 0;

        start_load(32'd512, 32'd2, 5, 1'b0, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (acc_cnt < 11 && n < 2000);
        check("midrst_reached", acc_cnt, 11);
        rst_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(32'd512, 32'd2, 5, 1'b0, 1'b0, "after_rst");

        run_load(32'd512, 32'd1, 3, 1'b0, 1'b1, "seqsum");
`ifdef PAT_LOAD_CHECKSUM_EN
        if (oc_q.size() == 3) check("sum136", {oc_q[1].addr, oc_q[1].data}, {11'h1, 256'd136});
        else check("sum136_count", oc_q.size(), 3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
